// File: rtl/clmul_unit.sv
// Multi-cycle carry-less multiplier (clmul/clmulh/clmulr), BITS_PER_CYCLE bits per iteration.
// Optional `CLMUL_EARLY_OUT_EN ends RUN once the remaining multiplier bits are all zero.
module clmul_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_a;
  logic [XLEN-1:0]     r_b;
  logic [1:0]          r_op;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_result;
  logic                r_out_valid;

  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]     w_b_nxt;
  logic [XLEN-1:0]     w_slice;
  logic                w_last;
  logic                w_accept;

  assign in_ready  = !stall && !flush &&
                     ((r_state == S_IDLE) ||
                      ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

  always_comb begin
    w_acc_nxt = r_acc;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (r_b[j]) w_acc_nxt = w_acc_nxt ^ (r_a << j);
    end
  end

  assign w_b_nxt = r_b >> BITS_PER_CYCLE;

`ifdef CLMUL_EARLY_OUT_EN
  assign w_last = (r_cnt == CW'(1)) || (w_b_nxt == '0);
`else
  assign w_last = (r_cnt == CW'(1));
`endif

  // Reserved op 11 falls through to the low-half slice.
  always_comb begin
    unique case (r_op)
      2'b01:   w_slice = w_acc_nxt[2*XLEN-1:XLEN];
      2'b10:   w_slice = w_acc_nxt[2*XLEN-2:XLEN-1];
      default: w_slice = w_acc_nxt[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else if (!stall) begin
      unique case (r_state)
        S_IDLE: ;
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a << BITS_PER_CYCLE;
          r_b   <= w_b_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_result    <= w_slice;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Accept overrides the DONE->IDLE move for back-to-back issue.
      if (w_accept) begin
        r_acc   <= '0;
        r_a     <= {{XLEN{1'b0}}, a};
        r_b     <= b;
        r_op    <= op;
        r_cnt   <= CW'(N);
        r_state <= S_RUN;
      end
    end
  end

endmodule
